// File: rtl/alu_operand_collector.sv
// ---------------------------------------------------------------------------
// alu_operand_collector
//
// Operand collection stage for one ALU pipe. Sits between the ALU reservation
// station issue port and the physical register file read arbiter:
//   1. Accepts one issued op (payload plus two source tags).
//   2. Holds a two-tag read request until the register file services it.
//   3. Latches both read bus words in the service cycle.
//   4. Presents op plus operands to the ALU with a valid/ready handshake.
//
// Optional feature: define ALU_OPERAND_STARVE_CHECK_EN to enable the
// read-starvation counter. When it is defined, DUT_error pulses for one cycle
// once STARVE_LIMIT consecutive unserviced READ cycles have elapsed. When it
// is not defined, DUT_error is tied to 0.
//
// Parameters
//   OP_WIDTH      width of the opaque op payload
//   STARVE_LIMIT  unserviced READ cycles before the starvation error
//   TAG_WIDTH     physical register tag width (phys_reg_tag_t)
//   WORD_WIDTH    register file word width (word_t)
//
// Ports
//   CLK, nRST                          clock, async active-low reset
//   DUT_error                          registered starvation error pulse
//   kill                               synchronous flush of the held op
//   issue_valid/issue_ready            RS issue handshake
//   issue_op, issue_tag_0/1            issued op payload and source tags
//   read_req_valid, read_req_0/1_tag   request to the register file arbiter
//   read_req_serviced                  arbiter granted the request this cycle
//   read_bus_0/1_data                  shared register file read buses
//   exec_valid/exec_ready              ALU handshake
//   exec_op, exec_operand_0/1          held op and latched operands
// ---------------------------------------------------------------------------
module alu_operand_collector #(
  parameter int OP_WIDTH     = 32,
  parameter int STARVE_LIMIT = 16,
  parameter int TAG_WIDTH    = 6,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  output logic                  DUT_error,
  input  logic                  kill,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [OP_WIDTH-1:0]   issue_op,
  input  logic [TAG_WIDTH-1:0]  issue_tag_0,
  input  logic [TAG_WIDTH-1:0]  issue_tag_1,
  output logic                  read_req_valid,
  output logic [TAG_WIDTH-1:0]  read_req_0_tag,
  output logic [TAG_WIDTH-1:0]  read_req_1_tag,
  input  logic                  read_req_serviced,
  input  logic [WORD_WIDTH-1:0] read_bus_0_data,
  input  logic [WORD_WIDTH-1:0] read_bus_1_data,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output logic [OP_WIDTH-1:0]   exec_op,
  output logic [WORD_WIDTH-1:0] exec_operand_0,
  output logic [WORD_WIDTH-1:0] exec_operand_1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic issue_fire;
  logic service_fire;

  logic [OP_WIDTH-1:0]   op_reg;
  logic [TAG_WIDTH-1:0]  tag_reg     [2];
  logic [WORD_WIDTH-1:0] operand_reg [2];

  // Per-source views of the issue tags and read buses so both source slots
  // can be built by one generate loop.
  logic [TAG_WIDTH-1:0]  issue_tag [2];
  logic [WORD_WIDTH-1:0] read_bus  [2];

  assign issue_tag[0] = issue_tag_0;
  assign issue_tag[1] = issue_tag_1;
  assign read_bus[0]  = read_bus_0_data;
  assign read_bus[1]  = read_bus_1_data;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. kill dominates every transition.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (issue_fire) begin
          state_next = READ;
        end
      end
      READ: begin
        if (read_req_serviced) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        // A new op may be accepted in the same cycle the ALU takes the
        // current one, so back-to-back ops skip the IDLE bubble.
        if (exec_ready) begin
          state_next = issue_fire ? READ : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (kill) begin
      state_next = IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs, combinational from state (issue_ready also sees the
  // ALU handshake and kill).
  // -------------------------------------------------------------------------
  always_comb begin
    read_req_valid = (state_reg == READ);
    exec_valid     = (state_reg == EXEC);
    issue_ready    = !kill && ((state_reg == IDLE) ||
                               ((state_reg == EXEC) && exec_ready));
  end

  assign issue_fire   = issue_valid && issue_ready;
  // Read buses are shared; they are only meaningful in a serviced READ cycle.
  assign service_fire = (state_reg == READ) && read_req_serviced && !kill;

  // -------------------------------------------------------------------------
  // Held op payload
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_reg <= '0;
    end else if (issue_fire) begin
      op_reg <= issue_op;
    end
  end

  // -------------------------------------------------------------------------
  // Per-source tag and operand registers
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          tag_reg[gi] <= '0;
        end else if (issue_fire) begin
          tag_reg[gi] <= issue_tag[gi];
        end
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          operand_reg[gi] <= '0;
        end else if (service_fire) begin
          operand_reg[gi] <= read_bus[gi];
        end
      end
    end
  endgenerate

  assign read_req_0_tag = tag_reg[0];
  assign read_req_1_tag = tag_reg[1];
  assign exec_op        = op_reg;
  assign exec_operand_0 = operand_reg[0];
  assign exec_operand_1 = operand_reg[1];

  // -------------------------------------------------------------------------
  // Read starvation detection
  // -------------------------------------------------------------------------
`ifdef ALU_OPERAND_STARVE_CHECK_EN
  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] starve_cnt_reg;
  logic [CNT_WIDTH-1:0] starve_cnt_next;
  logic                 error_reg;
  logic                 error_next;

  // Counter is zero outside READ, so entering READ always starts from 0.
  // It saturates at the limit so the error fires only once per episode.
  always_comb begin
    starve_cnt_next = '0;
    if ((state_reg == READ) && !read_req_serviced && !kill) begin
      if (starve_cnt_reg == CNT_LIMIT) begin
        starve_cnt_next = starve_cnt_reg;
      end else begin
        starve_cnt_next = starve_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  // Pulse only on the edge where the counter first reaches the limit.
  assign error_next = (starve_cnt_next == CNT_LIMIT) &&
                      (starve_cnt_reg != CNT_LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt_reg <= '0;
      error_reg      <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      error_reg      <= error_next;
    end
  end

  assign DUT_error = error_reg;
`else
  // Starvation check compiled out; the limit parameter has no effect.
  logic unused_starve_limit;
  assign unused_starve_limit = ^32'(STARVE_LIMIT);
  assign DUT_error = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_collector
//
// Self-checking bench for alu_operand_collector. Expected exec results are
// pushed to a scoreboard queue when an op is issued and popped/compared when
// the ALU handshake completes. Inputs change 1 ns after the rising edge;
// outputs are sampled 1 ns after the inputs settle.
// ---------------------------------------------------------------------------
module tb_alu_operand_collector;

  localparam int OP_W  = 32;
  localparam int TAG_W = 6;
  localparam int WRD_W = 32;
  localparam int LIMIT = 4;

  logic             CLK;
  logic             nRST;
  logic             DUT_error;
  logic             kill;
  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [TAG_W-1:0] issue_tag_0;
  logic [TAG_W-1:0] issue_tag_1;
  logic             read_req_valid;
  logic [TAG_W-1:0] read_req_0_tag;
  logic [TAG_W-1:0] read_req_1_tag;
  logic             read_req_serviced;
  logic [WRD_W-1:0] read_bus_0_data;
  logic [WRD_W-1:0] read_bus_1_data;
  logic             exec_valid;
  logic             exec_ready;
  logic [OP_W-1:0]  exec_op;
  logic [WRD_W-1:0] exec_operand_0;
  logic [WRD_W-1:0] exec_operand_1;

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [WRD_W-1:0] a;
    logic [WRD_W-1:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic [WRD_W-1:0] last_a;
  logic [WRD_W-1:0] last_b;

  alu_operand_collector #(
    .OP_WIDTH     (OP_W),
    .STARVE_LIMIT (LIMIT),
    .TAG_WIDTH    (TAG_W),
    .WORD_WIDTH   (WRD_W)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .DUT_error         (DUT_error),
    .kill              (kill),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_op          (issue_op),
    .issue_tag_0       (issue_tag_0),
    .issue_tag_1       (issue_tag_1),
    .read_req_valid    (read_req_valid),
    .read_req_0_tag    (read_req_0_tag),
    .read_req_1_tag    (read_req_1_tag),
    .read_req_serviced (read_req_serviced),
    .read_bus_0_data   (read_bus_0_data),
    .read_bus_1_data   (read_bus_1_data),
    .exec_valid        (exec_valid),
    .exec_ready        (exec_ready),
    .exec_op           (exec_op),
    .exec_operand_0    (exec_operand_0),
    .exec_operand_1    (exec_operand_1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    kill              = 1'b0;
    issue_valid       = 1'b0;
    issue_op          = '0;
    issue_tag_0       = '0;
    issue_tag_1       = '0;
    read_req_serviced = 1'b0;
    read_bus_0_data   = $urandom;
    read_bus_1_data   = $urandom;
    exec_ready        = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    #3;
    total++;
    if ({DUT_error, read_req_valid, exec_valid, issue_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_ctrl got err/rd/ex/ir=%b want 0001",
               {DUT_error, read_req_valid, exec_valid, issue_ready});
    end
    total++;
    if ({read_req_0_tag, read_req_1_tag, exec_op, exec_operand_0, exec_operand_1} !== '0) begin
      bad++;
      $display("FAIL reset_data got tags %0h/%0h op %0h opnd %0h/%0h want all 0",
               read_req_0_tag, read_req_1_tag, exec_op, exec_operand_0, exec_operand_1);
    end
    tick();
    tick();
    nRST = 1'b1;
    tick();
    total++;
    if ({read_req_valid, exec_valid, issue_ready} !== 3'b001) begin
      bad++;
      $display("FAIL post_reset_ctrl got rd/ex/ir=%b want 001",
               {read_req_valid, exec_valid, issue_ready});
    end
    $display("txn reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic();
    issue_valid = 1'b1;
    issue_op    = 32'hA5;
    issue_tag_0 = 6'd3;
    issue_tag_1 = 6'd7;
    #1;
    total++;
    if (issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_issue_ready got %b want 1", issue_ready);
    end
    sb.push_back('{op: 32'hA5, a: 32'h11, b: 32'h22});
    tick();
    idle_inputs();
    read_req_serviced = 1'b1;
    read_bus_0_data   = 32'h11;
    read_bus_1_data   = 32'h22;
    #1;
    total++;
    if ({read_req_valid, exec_valid, read_req_0_tag, read_req_1_tag} !== {1'b1, 1'b0, 6'd3, 6'd7}) begin
      bad++;
      $display("FAIL basic_read got rd=%b ex=%b tags %0d/%0d want rd=1 ex=0 tags 3/7",
               read_req_valid, exec_valid, read_req_0_tag, read_req_1_tag);
    end
    tick();
    idle_inputs();
    exec_ready = 1'b1;
    #1;
    total++;
    if (exec_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency got exec_valid=%b want 1", exec_valid);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL basic_sb got empty queue want one entry");
    end else begin
      e = sb.pop_front();
      if ({exec_op, exec_operand_0, exec_operand_1} !== {e.op, e.a, e.b}) begin
        bad++;
        $display("FAIL basic_exec got op %0h opnd %0h/%0h want op %0h opnd %0h/%0h",
                 exec_op, exec_operand_0, exec_operand_1, e.op, e.a, e.b);
      end
      $display("txn exec op=%0h a=%0h b=%0h", exec_op, exec_operand_0, exec_operand_1);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({exec_valid, read_req_valid, issue_ready} !== 3'b001) begin
      bad++;
      $display("FAIL basic_idle got ex/rd/ir=%b want 001", {exec_valid, read_req_valid, issue_ready});
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_read_stall();
    issue_valid = 1'b1;
    issue_op    = 32'h5A;
    issue_tag_0 = 6'd3;
    issue_tag_1 = 6'd7;
    sb.push_back('{op: 32'h5A, a: 32'h33, b: 32'h44});
    tick();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      // Unserviced noise on the shared buses must not be captured.
      issue_valid = 1'b1;
      issue_op    = $urandom;
      issue_tag_0 = 6'd9;
      issue_tag_1 = 6'd9;
      #1;
      total++;
      if ({read_req_valid, issue_ready, read_req_0_tag, read_req_1_tag, exec_op} !==
          {1'b1, 1'b0, 6'd3, 6'd7, 32'h5A}) begin
        bad++;
        $display("FAIL stall_hold cyc %0d got rd=%b ir=%b tags %0d/%0d op %0h want 1 0 3/7 5a",
                 i, read_req_valid, issue_ready, read_req_0_tag, read_req_1_tag, exec_op);
      end
      tick();
    end
    idle_inputs();
    read_req_serviced = 1'b1;
    read_bus_0_data   = 32'h33;
    read_bus_1_data   = 32'h44;
    tick();
    idle_inputs();
    exec_ready = 1'b1;
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL stall_sb got empty queue want one entry");
    end else begin
      e = sb.pop_front();
      total++;
      if ({exec_valid, exec_op, exec_operand_0, exec_operand_1} !== {1'b1, e.op, e.a, e.b}) begin
        bad++;
        $display("FAIL stall_exec got v=%b op %0h opnd %0h/%0h want v=1 op %0h opnd %0h/%0h",
                 exec_valid, exec_op, exec_operand_0, exec_operand_1, e.op, e.a, e.b);
      end
      $display("txn exec op=%0h a=%0h b=%0h", exec_op, exec_operand_0, exec_operand_1);
    end
    tick();
    idle_inputs();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    issue_valid = 1'b1;
    issue_op    = 32'h66;
    issue_tag_0 = 6'd1;
    issue_tag_1 = 6'd2;
    sb.push_back('{op: 32'h66, a: 32'hC0, b: 32'hC1});
    tick();
    idle_inputs();
    read_req_serviced = 1'b1;
    read_bus_0_data   = 32'hC0;
    read_bus_1_data   = 32'hC1;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      issue_valid = 1'b1;
      issue_op    = 32'hBAD;
      issue_tag_0 = 6'd5;
      issue_tag_1 = 6'd6;
      read_req_serviced = 1'b1;
      #1;
      total++;
      if ({exec_valid, issue_ready, exec_op, exec_operand_0, exec_operand_1} !==
          {1'b1, 1'b0, 32'h66, 32'hC0, 32'hC1}) begin
        bad++;
        $display("FAIL b2b_backpressure cyc %0d got v=%b ir=%b op %0h opnd %0h/%0h want 1 0 66 c0/c1",
                 i, exec_valid, issue_ready, exec_op, exec_operand_0, exec_operand_1);
      end
      tick();
    end
    idle_inputs();
    exec_ready  = 1'b1;
    issue_valid = 1'b1;
    issue_op    = 32'h77;
    issue_tag_0 = 6'd5;
    issue_tag_1 = 6'd6;
    #1;
    total++;
    if (issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_issue_ready got %b want 1", issue_ready);
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL b2b_sb got empty queue want one entry");
    end else begin
      e = sb.pop_front();
      total++;
      if ({exec_valid, exec_op, exec_operand_0, exec_operand_1} !== {1'b1, e.op, e.a, e.b}) begin
        bad++;
        $display("FAIL b2b_exec got v=%b op %0h opnd %0h/%0h want v=1 op %0h opnd %0h/%0h",
                 exec_valid, exec_op, exec_operand_0, exec_operand_1, e.op, e.a, e.b);
      end
      $display("txn exec op=%0h a=%0h b=%0h", exec_op, exec_operand_0, exec_operand_1);
    end
    sb.push_back('{op: 32'h77, a: 32'h55, b: 32'h66});
    tick();
    idle_inputs();
    read_req_serviced = 1'b1;
    read_bus_0_data   = 32'h55;
    read_bus_1_data   = 32'h66;
    #1;
    total++;
    if ({read_req_valid, exec_valid, read_req_0_tag, read_req_1_tag} !== {1'b1, 1'b0, 6'd5, 6'd6}) begin
      bad++;
      $display("FAIL b2b_no_bubble got rd=%b ex=%b tags %0d/%0d want rd=1 ex=0 tags 5/6",
               read_req_valid, exec_valid, read_req_0_tag, read_req_1_tag);
    end
    tick();
    idle_inputs();
    exec_ready = 1'b1;
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL b2b_sb2 got empty queue want one entry");
    end else begin
      e = sb.pop_front();
      total++;
      if ({exec_valid, exec_op, exec_operand_0, exec_operand_1} !== {1'b1, e.op, e.a, e.b}) begin
        bad++;
        $display("FAIL b2b_exec2 got v=%b op %0h opnd %0h/%0h want v=1 op %0h opnd %0h/%0h",
                 exec_valid, exec_op, exec_operand_0, exec_operand_1, e.op, e.a, e.b);
      end
      $display("txn exec op=%0h a=%0h b=%0h", exec_op, exec_operand_0, exec_operand_1);
    end
    last_a = 32'h55;
    last_b = 32'h66;
    tick();
    idle_inputs();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_kill();
    // Kill in READ while the arbiter services the request.
    issue_valid = 1'b1;
    issue_op    = 32'h99;
    issue_tag_0 = 6'd1;
    issue_tag_1 = 6'd2;
    tick();
    idle_inputs();
    kill              = 1'b1;
    read_req_serviced = 1'b1;
    read_bus_0_data   = 32'hDEAD;
    read_bus_1_data   = 32'hBEEF;
    issue_valid       = 1'b1;
    #1;
    total++;
    if (issue_ready !== 1'b0) begin
      bad++;
      $display("FAIL kill_read_ready got %b want 0", issue_ready);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({read_req_valid, exec_valid, issue_ready, exec_operand_0, exec_operand_1} !==
        {1'b0, 1'b0, 1'b1, last_a, last_b}) begin
      bad++;
      $display("FAIL kill_read got rd=%b ex=%b ir=%b opnd %0h/%0h want 0 0 1 %0h/%0h",
               read_req_valid, exec_valid, issue_ready, exec_operand_0, exec_operand_1,
               last_a, last_b);
    end
    $display("txn kill in READ");

    // Kill in EXEC with a competing issue.
    issue_valid = 1'b1;
    issue_op    = 32'h12;
    issue_tag_0 = 6'd4;
    issue_tag_1 = 6'd4;
    tick();
    idle_inputs();
    read_req_serviced = 1'b1;
    read_bus_0_data   = 32'hAA;
    read_bus_1_data   = 32'hBB;
    tick();
    idle_inputs();
    kill        = 1'b1;
    exec_ready  = 1'b1;
    issue_valid = 1'b1;
    issue_op    = 32'h34;
    issue_tag_0 = 6'd8;
    issue_tag_1 = 6'd8;
    #1;
    total++;
    if ({exec_valid, issue_ready} !== 2'b10) begin
      bad++;
      $display("FAIL kill_exec_same got ex=%b ir=%b want 1 0", exec_valid, issue_ready);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({exec_valid, read_req_valid, issue_ready, exec_op, read_req_0_tag} !==
        {1'b0, 1'b0, 1'b1, 32'h12, 6'd4}) begin
      bad++;
      $display("FAIL kill_exec got ex=%b rd=%b ir=%b op %0h tag0 %0d want 0 0 1 12 4",
               exec_valid, read_req_valid, issue_ready, exec_op, read_req_0_tag);
    end
    $display("txn kill in EXEC");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_starve();
    logic want;
    issue_valid = 1'b1;
    issue_op    = 32'h5;
    issue_tag_0 = 6'd10;
    issue_tag_1 = 6'd11;
    tick();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      tick();
      read_bus_0_data = $urandom;
      read_bus_1_data = $urandom;
`ifdef ALU_OPERAND_STARVE_CHECK_EN
      want = (k == LIMIT);
`else
      want = 1'b0;
`endif
      total++;
      if ({DUT_error, read_req_valid} !== {want, 1'b1}) begin
        bad++;
        $display("FAIL starve cyc %0d got err=%b rd=%b want err=%b rd=1",
                 k, DUT_error, read_req_valid, want);
      end
    end
    kill = 1'b1;
    tick();
    idle_inputs();
    $display("txn starvation window done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    issue_valid = 1'b1;
    issue_op    = 32'hF0;
    issue_tag_0 = 6'd12;
    issue_tag_1 = 6'd13;
    tick();
    idle_inputs();
    read_req_serviced = 1'b1;
    read_bus_0_data   = 32'h71;
    read_bus_1_data   = 32'h72;
    tick();
    idle_inputs();
    #1;
    total++;
    if ({exec_valid, exec_operand_0} !== {1'b1, 32'h71}) begin
      bad++;
      $display("FAIL areset_pre got ex=%b opnd0 %0h want 1 71", exec_valid, exec_operand_0);
    end
    #1;
    nRST = 1'b0;
    #1;
    total++;
    if ({exec_valid, issue_ready, exec_op, exec_operand_0, exec_operand_1, read_req_0_tag} !==
        {1'b1 ^ 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 6'd0}) begin
      bad++;
      $display("FAIL areset got ex=%b ir=%b op %0h opnd %0h/%0h tag0 %0d want 0 1 0 0/0 0",
               exec_valid, issue_ready, exec_op, exec_operand_0, exec_operand_1, read_req_0_tag);
    end
    tick();
    #2;
    nRST = 1'b1;
    $display("txn async reset in EXEC");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_read_stall();
    test_back_to_back();
    test_kill();
    test_starve();
    test_async_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish before 100us");
    $fatal(1, "timeout");
  end

endmodule
